// File: rtl/nvdla_sdp_cq_fifo_param_if.sv
// Valid/ready bus between the SDP command-queue FIFO and its ig producer / eg consumer,
// including flush, runtime write limit and the registered status outputs.
interface nvdla_sdp_cq_fifo_param_if #(
   parameter int DATA_W = 14,
   parameter int DEPTH  = 128
);
   localparam int CW = $clog2(DEPTH + 2);

   logic              in_pvld;
   logic              in_prdy;
   logic [DATA_W-1:0] in_pd;
   logic              out_pvld;
   logic              out_prdy;
   logic [DATA_W-1:0] out_pd;
   logic              flush;
   logic [CW-1:0]     wr_limit;
   logic [CW-1:0]     fifo_count;
   logic              almost_full;

   modport master (
      output in_pvld, in_pd, out_prdy, flush, wr_limit,
      input  in_prdy, out_pvld, out_pd, fifo_count, almost_full
   );

   modport slave (
      input  in_pvld, in_pd, out_prdy, flush, wr_limit,
      output in_prdy, out_pvld, out_pd, fifo_count, almost_full
   );
endinterface

// File: rtl/nvdla_sdp_cq_fifo_param.sv
// Parametrised single-clock valid/ready FIFO with registered output stage for SDP queues.
// Optional NVDLA_CQ_FIFO_BYPASS_EN lets a word skip the empty array straight into the output register.
module nvdla_sdp_cq_fifo_param #(
   parameter int DATA_W    = 14,
   parameter int DEPTH     = 128,
   parameter int AFULL_THR = DEPTH - 4
) (
   input logic                      nvdla_core_clk,
   input logic                      nvdla_core_rst,
   nvdla_sdp_cq_fifo_param_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 2);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THR);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     arr_count_q, arr_count_d;
   logic              out_pvld_q, out_pvld_d;
   logic [DATA_W-1:0] out_pd_q, out_pd_d;
   logic              in_prdy_q, in_prdy_d;
   logic [CW-1:0]     fifo_count_q, fifo_count_d;
   logic              almost_full_q, almost_full_d;
   logic              push, pop_out, arr_pop, arr_push, byp;
   logic              clr;

   assign clr = nvdla_core_rst | bus.flush;

   always_comb begin
      push    = bus.in_pvld & in_prdy_q;
      pop_out = out_pvld_q & bus.out_prdy;
      arr_pop = (arr_count_q != '0) & (!out_pvld_q | bus.out_prdy);
`ifdef NVDLA_CQ_FIFO_BYPASS_EN
      byp     = push & (arr_count_q == '0) & (!out_pvld_q | bus.out_prdy);
`else
      byp     = 1'b0;
`endif
      arr_push = push & !byp;

      // Power-of-two depth: pointers wrap naturally; arr_count alone tells full from empty.
      wr_ptr_d    = wr_ptr_q + AW'(arr_push);
      rd_ptr_d    = rd_ptr_q + AW'(arr_pop);
      arr_count_d = arr_count_q + CW'(arr_push) - CW'(arr_pop);

      out_pvld_d = arr_pop | byp | (out_pvld_q & !pop_out);
      out_pd_d   = out_pd_q;
      if (arr_pop) begin
         out_pd_d = mem_q[rd_ptr_q];
      end else if (byp) begin
         out_pd_d = bus.in_pd;
      end

      in_prdy_d = (arr_count_d != DEPTH_C) &
                  !((bus.wr_limit != '0) & (arr_count_d >= bus.wr_limit));
      fifo_count_d  = arr_count_d + CW'(out_pvld_d);
      almost_full_d = (arr_count_d >= AFULL_C);
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (clr) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         arr_count_q   <= '0;
         out_pvld_q    <= 1'b0;
         out_pd_q      <= '0;
         in_prdy_q     <= 1'b1;
         fifo_count_q  <= '0;
         almost_full_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         arr_count_q   <= arr_count_d;
         out_pvld_q    <= out_pvld_d;
         out_pd_q      <= out_pd_d;
         in_prdy_q     <= in_prdy_d;
         fifo_count_q  <= fifo_count_d;
         almost_full_q <= almost_full_d;
      end
   end

   // Storage is not reset; a flush or reset cycle must not write the dropped word.
   always_ff @(posedge nvdla_core_clk) begin
      if (arr_push & !clr) begin
         mem_q[wr_ptr_q] <= bus.in_pd;
      end
   end

   assign bus.in_prdy     = in_prdy_q;
   assign bus.out_pvld    = out_pvld_q;
   assign bus.out_pd      = out_pd_q;
   assign bus.fifo_count  = fifo_count_q;
   assign bus.almost_full = almost_full_q;
endmodule
